bram_tdp_be_clear: RTL and testbench
====================================

// Module: bram_tdp_be_clear
// PURPOSE
//  Parametrised true dual-port block RAM: the successor to the one-cycle TDP BRAM
//  template. Adds per-byte write enables, selectable read latency (1 or 2 cycles),
//  cross-port collision reporting, and a hardware clear engine that zeroes the array
//  after reset or on request. Used by unit-test harnesses as a shared scratch memory.
// PARAMETERS
//  DATA_WIDTH    32  word width in bits; must be a multiple of BYTE_WIDTH
//  ADDR_WIDTH    10  address bits; depth = 2**ADDR_WIDTH words
//  BYTE_WIDTH     8  bits per byte-enable lane; NBE = DATA_WIDTH/BYTE_WIDTH
//  READ_LATENCY   1  1 = registered read; 2 = extra output register (legal values: 1 or 2)
// PORTS
//  CLK         in   1           clock; all logic on the rising edge
//  RST_N       in   1           asynchronous, active-low reset
//  CLEAR_REQ   in   1           pulse: zero the whole array (ignored unless READY=1)
//  READY       out  1           1 = ports usable; 0 while clearing
//  ADDR_A/B    in   ADDR_WIDTH  word address
//  DI_A/B      in   DATA_WIDTH  write data
//  BE_A/B      in   NBE         byte-lane write enables; lane i covers DI[i*BYTE_WIDTH +: BYTE_WIDTH]
//  WE_A/B      in   1           write request (only effective with EN)
//  EN_A/B      in   1           port enable
//  DO_A/B      out  DATA_WIDTH  read data
//  DO_VALID_A/B out 1           DO valid for a read (EN & !WE) issued READY_LATENCY cycles earlier
//  COLLISION   out  1           registered pulse: same-address cross-port conflict detected
// BEHAVIOUR
//  Reset: DO_A/B=0, DO_VALID_A/B=0, COLLISION=0, READY=0, FSM enters CLEAR at addr 0.
//   Array contents are not reset directly; the clear engine zeroes them.
//  FSM: CLEAR -> RUN.
//   CLEAR: writes zero to addr counter 0..2**ADDR_WIDTH-1, one word per cycle, via
//    port A. User EN_A/EN_B are ignored; DO_VALID stays 0.
//   Last address written -> RUN next cycle; READY=1 from that cycle.
//   Clear duration is exactly 2**ADDR_WIDTH cycles after reset release.
//   RUN: CLEAR_REQ=1 -> CLEAR with the counter reset to 0; READY drops the next cycle.
//   In that cycle port operations still execute.
//  Write: EN & WE -> mem[ADDR] lanes with BE=1 take DI; lanes with BE=0 are unchanged.
//   WE with BE=0 modifies nothing.
//  Read: EN & !WE -> DO = mem[ADDR] after READY_LATENCY cycles; DO_VALID is high for 1 cycle.
//   With latency 2, the stage-2 register loads only when the stage-1 valid bit is set.
//   DO holds its last value when no read is in progress.
//  Same-port write with EN & WE: DO updates to the post-write word (write-first).
//   DO_VALID stays 0 for writes.
//  Back-to-back reads on each port: full throughput, one result per cycle.
//  Cross-port conflicts (both EN, ADDR_A==ADDR_B, at least one WE):
//   - both write: per-lane, port A wins where both BE set; B lanes with only B's BE set apply.
//   - one reads, one writes: reader returns the OLD word.
//   - COLLISION=1 in the next cycle for either case; never asserted for read/read.
//  Reset mid-clear or mid-read: outputs go to reset values immediately.
//   In-flight reads are dropped and the clear restarts from addr 0.
//  No X on outputs after reset; inputs are don't-care while READY=0.
// TESTING
//  1. Release reset, ADDR_WIDTH=4 -> READY rises exactly 16 cycles later.
//     Read every address -> 0, DO_VALID high each result.
//  2. RUN, A writes 0xDEADBEEF @5 (BE=1111); B writes BE=0010, DI=0x0000AA00 @5.
//     A reads @5 -> 0xDEADAABE? No: sequential cycles -> 0xDEADAAEF.
//  3. READ_LATENCY=2: reads @1,@2,@3 on consecutive cycles -> DO_VALID high cycles t+2..t+4.
//     Data is in order.
//  4. Same cycle: A writes 0x11111111 @7, B writes 0x22222222 @7 (all BE).
//     Result: mem[7]=0x11111111 and COLLISION pulses once.
//     Next: A writes 0x33 @7 while B reads @7 -> B gets 0x11111111, COLLISION=1.
//  5. Write data, pulse CLEAR_REQ -> READY low for 2**ADDR_WIDTH cycles.
//     Subsequent reads return 0; EN during the clear produces no DO_VALID.
//  6. Assert RST_N=0 halfway through a clear and during a pending latency-2 read.
//     Outputs zero at once, no stale DO_VALID, clear restarts from 0 after release.

Source files
------------

// File: rtl/bram_tdp_be_clear.sv
// True dual-port block RAM with per-byte write enables, 1- or 2-cycle read
// latency, cross-port collision reporting and a clear engine that zeroes the
// array after reset or on request. Port A wins per lane on same-address writes;
// a port that reads while the other writes the same word sees the old word.
module bram_tdp_be_clear #(
    parameter int  DATA_WIDTH   = 32,
    parameter int  ADDR_WIDTH   = 10,
    parameter int  BYTE_WIDTH   = 8,
    parameter int  READ_LATENCY = 1,
    localparam int NBE          = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  CLEAR_REQ,
    output logic                  READY,
    input  logic [ADDR_WIDTH-1:0] ADDR_A,
    input  logic [DATA_WIDTH-1:0] DI_A,
    input  logic [NBE-1:0]        BE_A,
    input  logic                  WE_A,
    input  logic                  EN_A,
    output logic [DATA_WIDTH-1:0] DO_A,
    output logic                  DO_VALID_A,
    input  logic [ADDR_WIDTH-1:0] ADDR_B,
    input  logic [DATA_WIDTH-1:0] DI_B,
    input  logic [NBE-1:0]        BE_B,
    input  logic                  WE_B,
    input  logic                  EN_B,
    output logic [DATA_WIDTH-1:0] DO_B,
    output logic                  DO_VALID_B,
    output logic                  COLLISION
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t                  state_reg;
    logic [ADDR_WIDTH-1:0]   clear_cnt_reg;
    logic                    ready_reg;
    logic                    vld1_a_reg;
    logic                    vld1_b_reg;
    logic                    collision_reg;
    logic [DATA_WIDTH-1:0]   do1_a;
    logic [DATA_WIDTH-1:0]   do1_b;

    // User port activity is only honoured in RUN; the clear engine owns port A otherwise
    logic clearing;
    logic act_a, act_b, wr_a, wr_b, same_addr;

    assign clearing  = (state_reg == ST_CLEAR);
    assign act_a     = !clearing && EN_A;
    assign act_b     = !clearing && EN_B;
    assign wr_a      = act_a && WE_A;
    assign wr_b      = act_b && WE_B;
    assign same_addr = (ADDR_A == ADDR_B);

    assign READY     = ready_reg;
    assign COLLISION = collision_reg;

    // Clear/run sequencer: sweep every address once, then hand the ports to the user
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_reg     <= ST_CLEAR;
            clear_cnt_reg <= '0;
            ready_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_CLEAR: begin
                    if (clear_cnt_reg == {ADDR_WIDTH{1'b1}}) begin
                        state_reg     <= ST_RUN;
                        ready_reg     <= 1'b1;
                        clear_cnt_reg <= '0;
                    end else begin
                        clear_cnt_reg <= clear_cnt_reg + 1'b1;
                    end
                end
                default: begin
                    if (CLEAR_REQ) begin
                        state_reg     <= ST_CLEAR;
                        clear_cnt_reg <= '0;
                        ready_reg     <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Stage-1 read valids and the collision pulse (read/read never collides)
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vld1_a_reg    <= 1'b0;
            vld1_b_reg    <= 1'b0;
            collision_reg <= 1'b0;
        end else begin
            vld1_a_reg    <= act_a && !WE_A;
            vld1_b_reg    <= act_b && !WE_B;
            collision_reg <= act_a && act_b && same_addr && (WE_A || WE_B);
        end
    end

    // One narrow memory per byte lane so each lane has its own write enable
    for (genvar gi = 0; gi < NBE; gi++) begin : g_lane
        logic [BYTE_WIDTH-1:0] mem_lane [DEPTH];
        logic [BYTE_WIDTH-1:0] di_a_lane, di_b_lane;
        logic [BYTE_WIDTH-1:0] q_a_reg, q_b_reg;
        logic                  lane_we_a, lane_we_b;

        assign di_a_lane = DI_A[gi*BYTE_WIDTH +: BYTE_WIDTH];
        assign di_b_lane = DI_B[gi*BYTE_WIDTH +: BYTE_WIDTH];
        assign lane_we_a = wr_a && BE_A[gi];
        assign lane_we_b = wr_b && BE_B[gi];

        // Lane storage: B first so that A's later assignment wins on a shared address
        always_ff @(posedge CLK) begin
            if (lane_we_b) begin
                mem_lane[ADDR_B] <= di_b_lane;
            end
            if (clearing) begin
                mem_lane[clear_cnt_reg] <= '0;
            end else if (lane_we_a) begin
                mem_lane[ADDR_A] <= di_a_lane;
            end
        end

        // Registered read: a writing port sees the final stored word, a reading port the old one
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                q_a_reg <= '0;
                q_b_reg <= '0;
            end else begin
                if (act_a) begin
                    q_a_reg <= lane_we_a ? di_a_lane :
                               (wr_a && same_addr && lane_we_b) ? di_b_lane :
                               mem_lane[ADDR_A];
                end
                if (act_b) begin
                    q_b_reg <= (wr_b && same_addr && lane_we_a) ? di_a_lane :
                               lane_we_b ? di_b_lane :
                               mem_lane[ADDR_B];
                end
            end
        end

        assign do1_a[gi*BYTE_WIDTH +: BYTE_WIDTH] = q_a_reg;
        assign do1_b[gi*BYTE_WIDTH +: BYTE_WIDTH] = q_b_reg;
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] do2_a_reg, do2_b_reg;
        logic                  vld2_a_reg, vld2_b_reg;

        // Extra output stage, loaded only behind a genuine read result
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                do2_a_reg  <= '0;
                do2_b_reg  <= '0;
                vld2_a_reg <= 1'b0;
                vld2_b_reg <= 1'b0;
            end else begin
                vld2_a_reg <= vld1_a_reg;
                vld2_b_reg <= vld1_b_reg;
                if (vld1_a_reg) begin
                    do2_a_reg <= do1_a;
                end
                if (vld1_b_reg) begin
                    do2_b_reg <= do1_b;
                end
            end
        end

        assign DO_A       = do2_a_reg;
        assign DO_B       = do2_b_reg;
        assign DO_VALID_A = vld2_a_reg;
        assign DO_VALID_B = vld2_b_reg;
    end else begin : g_lat1
        assign DO_A       = do1_a;
        assign DO_B       = do1_b;
        assign DO_VALID_A = vld1_a_reg;
        assign DO_VALID_B = vld1_b_reg;
    end

endmodule

// File: tb/tb_bram_tdp_be_clear.sv
// Bench for bram_tdp_be_clear: one latency-1 and one latency-2 instance share
// the same stimulus. Read results are checked through a scoreboard queue that
// records the expected word and the cycle it is due on each output port.
module tb_bram_tdp_be_clear;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int NBE = 4;

    logic           CLK = 1'b0;
    logic           RST_N = 1'b0;
    logic           CLEAR_REQ = 1'b0;
    logic [AW-1:0]  ADDR_A = '0, ADDR_B = '0;
    logic [DW-1:0]  DI_A = '0, DI_B = '0;
    logic [NBE-1:0] BE_A = '0, BE_B = '0;
    logic           WE_A = 1'b0, WE_B = 1'b0, EN_A = 1'b0, EN_B = 1'b0;

    logic           READY1, READY2, COLLISION1, COLLISION2;
    logic [DW-1:0]  DO_A1, DO_B1, DO_A2, DO_B2;
    logic           DO_VALID_A1, DO_VALID_B1, DO_VALID_A2, DO_VALID_B2;

    bram_tdp_be_clear #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .READ_LATENCY(1)) u_dut_l1 (
        .CLK(CLK), .RST_N(RST_N), .CLEAR_REQ(CLEAR_REQ), .READY(READY1),
        .ADDR_A(ADDR_A), .DI_A(DI_A), .BE_A(BE_A), .WE_A(WE_A), .EN_A(EN_A),
        .DO_A(DO_A1), .DO_VALID_A(DO_VALID_A1),
        .ADDR_B(ADDR_B), .DI_B(DI_B), .BE_B(BE_B), .WE_B(WE_B), .EN_B(EN_B),
        .DO_B(DO_B1), .DO_VALID_B(DO_VALID_B1),
        .COLLISION(COLLISION1)
    );

    bram_tdp_be_clear #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(8), .READ_LATENCY(2)) u_dut_l2 (
        .CLK(CLK), .RST_N(RST_N), .CLEAR_REQ(CLEAR_REQ), .READY(READY2),
        .ADDR_A(ADDR_A), .DI_A(DI_A), .BE_A(BE_A), .WE_A(WE_A), .EN_A(EN_A),
        .DO_A(DO_A2), .DO_VALID_A(DO_VALID_A2),
        .ADDR_B(ADDR_B), .DI_B(DI_B), .BE_B(BE_B), .WE_B(WE_B), .EN_B(EN_B),
        .DO_B(DO_B2), .DO_VALID_B(DO_VALID_B2),
        .COLLISION(COLLISION2)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: port 0=A/lat1, 1=A/lat2, 2=B/lat1, 3=B/lat2
    typedef struct {
        int            port;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sbq[$];

    typedef struct packed {
        logic           en_a;
        logic           we_a;
        logic [NBE-1:0] be_a;
        logic [AW-1:0]  addr_a;
        logic [DW-1:0]  di_a;
        logic           en_b;
        logic           we_b;
        logic [NBE-1:0] be_b;
        logic [AW-1:0]  addr_b;
        logic [DW-1:0]  di_b;
        logic           col;
        logic [DW-1:0]  exp_a;
        logic [DW-1:0]  exp_b;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mkv(logic ea, logic wa, logic [3:0] ba, logic [3:0] aa, logic [31:0] da,
                                 logic eb, logic wb, logic [3:0] bb, logic [3:0] ab, logic [31:0] db,
                                 logic col, logic [31:0] xa, logic [31:0] xb);
        vec_t v;
        v.en_a = ea; v.we_a = wa; v.be_a = ba; v.addr_a = aa; v.di_a = da;
        v.en_b = eb; v.we_b = wb; v.be_b = bb; v.addr_b = ab; v.di_b = db;
        v.col = col; v.exp_a = xa; v.exp_b = xb;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(int port, logic [DW-1:0] data, int due);
        exp_t e;
        e.port = port; e.data = data; e.due = due;
        sbq.push_back(e);
    endtask

    task automatic idle();
        EN_A = 1'b0; EN_B = 1'b0; WE_A = 1'b0; WE_B = 1'b0;
        BE_A = '0;   BE_B = '0;   CLEAR_REQ = 1'b0;
    endtask

    // Apply one vector and register the reads it issues with the scoreboard
    task automatic drive(vec_t v);
        EN_A = v.en_a; WE_A = v.we_a; BE_A = v.be_a; ADDR_A = v.addr_a; DI_A = v.di_a;
        EN_B = v.en_b; WE_B = v.we_b; BE_B = v.be_b; ADDR_B = v.addr_b; DI_B = v.di_b;
        if (v.en_a && !v.we_a) begin
            push(0, v.exp_a, cyc + 1);
            push(1, v.exp_a, cyc + 2);
        end
        if (v.en_b && !v.we_b) begin
            push(2, v.exp_b, cyc + 1);
            push(3, v.exp_b, cyc + 2);
        end
    endtask

    // Number of sampled cycles with READY low, bounded
    task automatic count_low(output int n);
        n = 0;
        while (!(READY1 && READY2) && n < 100) begin
            n++;
            @(negedge CLK);
        end
    endtask

    logic          vld [4];
    logic [DW-1:0] dat [4];
    always_comb begin
        vld[0] = DO_VALID_A1; vld[1] = DO_VALID_A2; vld[2] = DO_VALID_B1; vld[3] = DO_VALID_B2;
        dat[0] = DO_A1;       dat[1] = DO_A2;       dat[2] = DO_B1;       dat[3] = DO_B2;
    end

    int mon_idx;
    int mon_j;

    // Result monitor: match every DO_VALID against the oldest expectation for that port
    always @(negedge CLK) begin
        if (RST_N) begin
            for (int k = 0; k < 4; k++) begin
                if (vld[k]) begin
                    mon_idx = -1;
                    for (int j = 0; j < sbq.size(); j++) begin
                        if (mon_idx < 0 && sbq[j].port == k) mon_idx = j;
                    end
                    checks++;
                    if (mon_idx < 0) begin
                        errors++;
                        $display("FAIL rd_unexpected port=%0d cyc=%0d got %h expected no result", k, cyc, dat[k]);
                    end else begin
                        $display("rd port=%0d cyc=%0d data=%h", k, cyc, dat[k]);
                        if (dat[k] !== sbq[mon_idx].data || sbq[mon_idx].due != cyc) begin
                            errors++;
                            $display("FAIL rd_data port=%0d got %h at cyc %0d expected %h at cyc %0d",
                                     k, dat[k], cyc, sbq[mon_idx].data, sbq[mon_idx].due);
                        end
                        sbq.delete(mon_idx);
                    end
                end
            end
            mon_j = 0;
            while (mon_j < sbq.size()) begin
                if (sbq[mon_j].due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_missing port=%0d got nothing expected %h at cyc %0d",
                             sbq[mon_j].port, sbq[mon_j].data, sbq[mon_j].due);
                    sbq.delete(mon_j);
                end else begin
                    mon_j++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    int n;

    initial begin
        // en we be addr data | en we be addr data | col exp_a exp_b
        tbl.push_back(mkv(1,1,4'hF,4'd5,32'hDEADBEEF, 0,0,4'h0,4'd0,32'h0,        0, 32'h0,        32'h0));
        tbl.push_back(mkv(0,0,4'h0,4'd0,32'h0,        1,1,4'h2,4'd5,32'h0000AA00, 0, 32'h0,        32'h0));
        tbl.push_back(mkv(1,0,4'h0,4'd5,32'h0,        0,0,4'h0,4'd0,32'h0,        0, 32'hDEADAAEF, 32'h0));
        tbl.push_back(mkv(1,1,4'hF,4'd7,32'h11111111, 1,1,4'hF,4'd7,32'h22222222, 1, 32'h0,        32'h0));
        tbl.push_back(mkv(1,1,4'hF,4'd7,32'h00000033, 1,0,4'h0,4'd7,32'h0,        1, 32'h0,        32'h11111111));
        tbl.push_back(mkv(1,0,4'h0,4'd7,32'h0,        1,0,4'h0,4'd7,32'h0,        0, 32'h00000033, 32'h00000033));
        tbl.push_back(mkv(1,1,4'h5,4'd9,32'hAAAAAAAA, 1,1,4'h6,4'd9,32'hBBBBBBBB, 1, 32'h0,        32'h0));
        tbl.push_back(mkv(1,0,4'h0,4'd9,32'h0,        1,0,4'h0,4'd9,32'h0,        0, 32'h00AABBAA, 32'h00AABBAA));
        tbl.push_back(mkv(1,1,4'h0,4'd9,32'hFFFFFFFF, 1,0,4'h0,4'd3,32'h0,        0, 32'h0,        32'h0));
        tbl.push_back(mkv(1,0,4'h0,4'd9,32'h0,        1,1,4'h8,4'd3,32'hAB0000CD, 0, 32'h00AABBAA, 32'h0));
        tbl.push_back(mkv(1,0,4'h0,4'd5,32'h0,        1,0,4'h0,4'd3,32'h0,        0, 32'hDEADAAEF, 32'hAB000000));
        tbl.push_back(mkv(0,0,4'h0,4'd0,32'h0,        1,1,4'hF,4'd1,32'h01010101, 0, 32'h0,        32'h0));
        tbl.push_back(mkv(0,0,4'h0,4'd0,32'h0,        1,1,4'hF,4'd2,32'h02020202, 0, 32'h0,        32'h0));
        tbl.push_back(mkv(1,0,4'h0,4'd1,32'h0,        1,0,4'h0,4'd5,32'h0,        0, 32'h01010101, 32'hDEADAAEF));
        tbl.push_back(mkv(1,0,4'h0,4'd2,32'h0,        1,0,4'h0,4'd9,32'h0,        0, 32'h02020202, 32'h00AABBAA));
        tbl.push_back(mkv(1,0,4'h0,4'd3,32'h0,        1,0,4'h0,4'd7,32'h0,        0, 32'hAB000000, 32'h00000033));
        tbl.push_back(mkv(1,1,4'hF,4'd10,32'h0A0A0A0A,1,1,4'hF,4'd11,32'h0B0B0B0B,0, 32'h0,        32'h0));
        tbl.push_back(mkv(1,0,4'h0,4'd11,32'h0,       1,0,4'h0,4'd10,32'h0,       0, 32'h0B0B0B0B, 32'h0A0A0A0A));

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_ready_l1", {31'd0, READY1}, 32'd0);
        chk("rst_ready_l2", {31'd0, READY2}, 32'd0);
        chk("rst_do_a_l2", DO_A2, 32'd0);
        chk("rst_do_b_l1", DO_B1, 32'd0);
        chk("rst_valid", {28'd0, DO_VALID_A1, DO_VALID_B1, DO_VALID_A2, DO_VALID_B2}, 32'd0);
        chk("rst_collision", {30'd0, COLLISION1, COLLISION2}, 32'd0);

        // Power-up clear takes exactly 16 cycles, then every word reads zero
        RST_N = 1'b1;
        count_low(n);
        chk("powerup_clear_len", n, 32'd16);
        for (int i = 0; i < 16; i++) begin
            drive(mkv(1,0,4'h0,4'(i),32'h0, 1,0,4'h0,4'(15-i),32'h0, 0, 32'h0, 32'h0));
            @(negedge CLK);
        end
        idle();
        repeat (3) @(negedge CLK);

        // Table: byte enables, collisions, back-to-back reads
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge CLK);
            chk($sformatf("collision_l1[%0d]", i), {31'd0, COLLISION1}, {31'd0, tbl[i].col});
            chk($sformatf("collision_l2[%0d]", i), {31'd0, COLLISION2}, {31'd0, tbl[i].col});
        end
        idle();
        repeat (3) @(negedge CLK);

        // Write-first on the writing port; latency-2 output holds its last read
        drive(mkv(1,1,4'h3,4'd12,32'h5A5A5A5A, 0,0,4'h0,4'd0,32'h0, 0, 32'h0, 32'h0));
        @(negedge CLK);
        chk("write_first_do_a_l1", DO_A1, 32'h00005A5A);
        idle();
        @(negedge CLK);
        chk("hold_do_a_l1", DO_A1, 32'h00005A5A);
        chk("hold_do_a_l2", DO_A2, 32'h0B0B0B0B);

        // Clear request: READY low 16 cycles, EN ignored meanwhile, contents zeroed
        drive(mkv(1,1,4'hF,4'd2,32'h12345678, 0,0,4'h0,4'd0,32'h0, 0, 32'h0, 32'h0));
        @(negedge CLK);
        drive(mkv(1,0,4'h0,4'd2,32'h0, 0,0,4'h0,4'd0,32'h0, 0, 32'h12345678, 32'h0));
        @(negedge CLK);
        idle();
        repeat (2) @(negedge CLK);
        CLEAR_REQ = 1'b1;
        @(negedge CLK);
        CLEAR_REQ = 1'b0;
        EN_A = 1'b1; ADDR_A = 4'd2; EN_B = 1'b1; ADDR_B = 4'd5;
        count_low(n);
        chk("request_clear_len", n, 32'd16);
        idle();
        drive(mkv(1,0,4'h0,4'd2,32'h0, 1,0,4'h0,4'd5,32'h0, 0, 32'h0, 32'h0));
        @(negedge CLK);
        idle();
        repeat (3) @(negedge CLK);

        // Reset with a latency-2 read in flight
        drive(mkv(1,1,4'hF,4'd4,32'hCAFEF00D, 0,0,4'h0,4'd0,32'h0, 0, 32'h0, 32'h0));
        @(negedge CLK);
        drive(mkv(1,0,4'h0,4'd4,32'h0, 0,0,4'h0,4'd0,32'h0, 0, 32'hCAFEF00D, 32'h0));
        @(negedge CLK);
        EN_A = 1'b1; WE_A = 1'b0; ADDR_A = 4'd4;
        push(0, 32'hCAFEF00D, cyc + 1);
        @(negedge CLK);
        idle();
        #2;
        RST_N = 1'b0;
        sbq.delete();
        #1;
        chk("midread_rst_do_a_l1", DO_A1, 32'd0);
        chk("midread_rst_do_a_l2", DO_A2, 32'd0);
        chk("midread_rst_valid", {30'd0, DO_VALID_A1, DO_VALID_A2}, 32'd0);
        chk("midread_rst_ready", {30'd0, READY1, READY2}, 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Reset halfway through the clear: it restarts from address 0
        repeat (8) @(negedge CLK);
        chk("midclear_ready", {30'd0, READY1, READY2}, 32'd0);
        #2;
        RST_N = 1'b0;
        #1;
        chk("midclear_rst_outputs", {30'd0, DO_VALID_A2, COLLISION1}, 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        count_low(n);
        chk("restart_clear_len", n, 32'd16);
        drive(mkv(1,0,4'h0,4'd4,32'h0, 1,0,4'h0,4'd5,32'h0, 0, 32'h0, 32'h0));
        @(negedge CLK);
        idle();
        repeat (4) @(negedge CLK);

        chk("scoreboard_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
